// File: rtl/ec_scalar_mul_if.sv
// ---------------------------------------------------------------------------
// ec_scalar_mul_if
// Point-addition handshake between the scalar-multiply sequencer (master) and
// the point_add unit (slave).
//   pa_start              : one-cycle launch pulse (master -> slave)
//   pa_x1/pa_y1/pa_inf1   : operand 1 (master -> slave)
//   pa_x2/pa_y2/pa_inf2   : operand 2 (master -> slave)
//   pa_done               : one-cycle completion pulse (slave -> master)
//   pa_x3/pa_y3/pa_inf3   : result (slave -> master)
// ---------------------------------------------------------------------------
interface ec_scalar_mul_if;
   localparam int unsigned CW = 256;

   logic          pa_start;
   logic [CW-1:0] pa_x1;
   logic [CW-1:0] pa_y1;
   logic          pa_inf1;
   logic [CW-1:0] pa_x2;
   logic [CW-1:0] pa_y2;
   logic          pa_inf2;
   logic          pa_done;
   logic [CW-1:0] pa_x3;
   logic [CW-1:0] pa_y3;
   logic          pa_inf3;

   modport master (
      output pa_start, pa_x1, pa_y1, pa_inf1, pa_x2, pa_y2, pa_inf2,
      input  pa_done, pa_x3, pa_y3, pa_inf3
   );

   modport slave (
      input  pa_start, pa_x1, pa_y1, pa_inf1, pa_x2, pa_y2, pa_inf2,
      output pa_done, pa_x3, pa_y3, pa_inf3
   );
endinterface

// File: rtl/ec_scalar_mul.sv
// ---------------------------------------------------------------------------
// ec_scalar_mul
// Left-to-right double-and-add sequencer for R = k*P (secp256k1, affine).
// Performs no field arithmetic; every double/add is delegated to an external
// point_add unit through the pa interface.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, k, px, py,   : request and operands, latched when accepted in IDLE
//   pinf
//   busy, done          : busy from the cycle after accept through done;
//                         done is a one-cycle pulse
//   rx, ry, rinf        : result, held until the next done
//   pa                  : master side of the point_add handshake
// ---------------------------------------------------------------------------
module ec_scalar_mul #(
   parameter  int unsigned KBITS = 256,
   localparam int unsigned CW    = 256,
   localparam int unsigned IW    = (KBITS > 1) ? $clog2(KBITS) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [KBITS-1:0]       k,
   input  logic [CW-1:0]          px,
   input  logic [CW-1:0]          py,
   input  logic                   pinf,
   output logic                   busy,
   output logic                   done,
   output logic [CW-1:0]          rx,
   output logic [CW-1:0]          ry,
   output logic                   rinf,
   ec_scalar_mul_if.master        pa
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SETUP    = 3'd1;
   localparam logic [2:0] S_DBL_REQ  = 3'd2;
   localparam logic [2:0] S_DBL_WAIT = 3'd3;
   localparam logic [2:0] S_ADD_REQ  = 3'd4;
   localparam logic [2:0] S_ADD_WAIT = 3'd5;
   localparam logic [2:0] S_NEXT     = 3'd6;
   localparam logic [2:0] S_FINISH   = 3'd7;

   logic [2:0]       state, state_d;
   logic [KBITS-1:0] k_q, k_d;
   logic [CW-1:0]    px_q, px_d, py_q, py_d;
   logic             pinf_q, pinf_d;
   logic [CW-1:0]    ax_q, ax_d, ay_q, ay_d;
   logic             ainf_q, ainf_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             busy_d, done_d, rinf_d;
   logic [CW-1:0]    rx_d, ry_d;
   logic             pa_start_d, pa_inf1_d, pa_inf2_d;
   logic [CW-1:0]    pa_x1_d, pa_y1_d, pa_x2_d, pa_y2_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         k_q         <= '0;
         px_q        <= '0;
         py_q        <= '0;
         pinf_q      <= 1'b0;
         ax_q        <= '0;
         ay_q        <= '0;
         ainf_q      <= 1'b1;
         idx_q       <= IW'(KBITS - 1);
         busy        <= 1'b0;
         done        <= 1'b0;
         rx          <= '0;
         ry          <= '0;
         rinf        <= 1'b0;
         pa.pa_start <= 1'b0;
         pa.pa_x1    <= '0;
         pa.pa_y1    <= '0;
         pa.pa_inf1  <= 1'b0;
         pa.pa_x2    <= '0;
         pa.pa_y2    <= '0;
         pa.pa_inf2  <= 1'b0;
      end else begin
         state       <= state_d;
         k_q         <= k_d;
         px_q        <= px_d;
         py_q        <= py_d;
         pinf_q      <= pinf_d;
         ax_q        <= ax_d;
         ay_q        <= ay_d;
         ainf_q      <= ainf_d;
         idx_q       <= idx_d;
         busy        <= busy_d;
         done        <= done_d;
         rx          <= rx_d;
         ry          <= ry_d;
         rinf        <= rinf_d;
         pa.pa_start <= pa_start_d;
         pa.pa_x1    <= pa_x1_d;
         pa.pa_y1    <= pa_y1_d;
         pa.pa_inf1  <= pa_inf1_d;
         pa.pa_x2    <= pa_x2_d;
         pa.pa_y2    <= pa_y2_d;
         pa.pa_inf2  <= pa_inf2_d;
      end
   end

   // Next-state and next-output logic. pa_start is registered, so the REQ
   // state between a pa_done and the following launch already guarantees at
   // least two cycles of separation on every path.
   always_comb begin
      state_d    = state;
      k_d        = k_q;
      px_d       = px_q;
      py_d       = py_q;
      pinf_d     = pinf_q;
      ax_d       = ax_q;
      ay_d       = ay_q;
      ainf_d     = ainf_q;
      idx_d      = idx_q;
      busy_d     = busy;
      done_d     = 1'b0;
      rx_d       = rx;
      ry_d       = ry;
      rinf_d     = rinf;
      pa_start_d = 1'b0;
      pa_x1_d    = pa.pa_x1;
      pa_y1_d    = pa.pa_y1;
      pa_inf1_d  = pa.pa_inf1;
      pa_x2_d    = pa.pa_x2;
      pa_y2_d    = pa.pa_y2;
      pa_inf2_d  = pa.pa_inf2;

      case (state)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               k_d     = k;
               px_d    = px;
               py_d    = py;
               pinf_d  = pinf;
               ax_d    = '0;
               ay_d    = '0;
               ainf_d  = 1'b1;
               idx_d   = IW'(KBITS - 1);
               busy_d  = 1'b1;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            state_d = ((k_q == '0) || pinf_q) ? S_FINISH : S_DBL_REQ;
         end
         S_DBL_REQ: begin
            // Doubling infinity is a no-op; go straight to the add decision.
            if (ainf_q) begin
               state_d = k_q[idx_q] ? S_ADD_REQ : S_NEXT;
            end else begin
               pa_start_d = 1'b1;
               pa_x1_d    = ax_q;
               pa_y1_d    = ay_q;
               pa_inf1_d  = ainf_q;
               pa_x2_d    = ax_q;
               pa_y2_d    = ay_q;
               pa_inf2_d  = ainf_q;
               state_d    = S_DBL_WAIT;
            end
         end
         S_DBL_WAIT: begin
            if (pa.pa_done) begin
               ax_d    = pa.pa_x3;
               ay_d    = pa.pa_y3;
               ainf_d  = pa.pa_inf3;
               state_d = k_q[idx_q] ? S_ADD_REQ : S_NEXT;
            end
         end
         S_ADD_REQ: begin
            pa_start_d = 1'b1;
            pa_x1_d    = ax_q;
            pa_y1_d    = ay_q;
            pa_inf1_d  = ainf_q;
            pa_x2_d    = px_q;
            pa_y2_d    = py_q;
            pa_inf2_d  = 1'b0;
            state_d    = S_ADD_WAIT;
         end
         S_ADD_WAIT: begin
            if (pa.pa_done) begin
               ax_d    = pa.pa_x3;
               ay_d    = pa.pa_y3;
               ainf_d  = pa.pa_inf3;
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (idx_q == '0) begin
               state_d = S_FINISH;
            end else begin
               idx_d   = idx_q - IW'(1);
               state_d = S_DBL_REQ;
            end
         end
         S_FINISH: begin
            rx_d    = ax_q;
            ry_d    = ay_q;
            rinf_d  = ainf_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ec_scalar_mul.sv
// ---------------------------------------------------------------------------
// tb_ec_scalar_mul
// Bench for ec_scalar_mul: a behavioural secp256k1 point_add responder with
// programmable latency, plus a reference k*P computed right-to-left.
// ---------------------------------------------------------------------------
module tb_ec_scalar_mul;
   localparam int unsigned KBITS = 256;

   typedef struct packed {
      logic         inf;
      logic [255:0] x;
      logic [255:0] y;
   } pt_t;

   localparam logic [255:0] FP  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
   localparam logic [255:0] NO  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
   localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
   localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
   localparam logic [255:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
   localparam logic [255:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
   localparam logic [255:0] G3X = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
   localparam logic [255:0] G3Y = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;
   localparam int LIMIT = 20000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start;
   logic [KBITS-1:0] k;
   logic [255:0]     px, py;
   logic             pinf;
   logic             busy, done, rinf;
   logic [255:0]     rx, ry;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_pa = 0;
   int lat = 10;
   int last_done = -100;
   bit spur = 1'b0;

   ec_scalar_mul_if pa();

   ec_scalar_mul #(.KBITS(KBITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .k     (k),
      .px    (px),
      .py    (py),
      .pinf  (pinf),
      .busy  (busy),
      .done  (done),
      .rx    (rx),
      .ry    (ry),
      .rinf  (rinf),
      .pa    (pa)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- field / group arithmetic ----------------
   function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
      logic [511:0] t;
      t = 512'(a) * 512'(b);
      return 256'(t % 512'(FP));
   endfunction

   function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
      logic [256:0] s;
      s = 257'(a) + 257'(b);
      if (s >= 257'(FP)) s = s - 257'(FP);
      return 256'(s);
   endfunction

   function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
      logic [256:0] s;
      if (a >= b) s = 257'(a) - 257'(b);
      else        s = 257'(a) + 257'(FP) - 257'(b);
      return 256'(s);
   endfunction

   function automatic logic [255:0] finv(input logic [255:0] a);
      logic [255:0] r, b, e;
      r = 256'd1;
      b = a;
      e = FP - 256'd2;
      for (int i = 0; i < 256; i++) begin
         if (e[i]) r = fmul(r, b);
         b = fmul(b, b);
      end
      return r;
   endfunction

   function automatic pt_t ec_add(input pt_t a, input pt_t b);
      pt_t r;
      logic [255:0] num, den, l;
      if (a.inf) return b;
      if (b.inf) return a;
      if (a.x == b.x) begin
         if (a.y != b.y || a.y == '0) begin
            r.inf = 1'b1; r.x = '0; r.y = '0;
            return r;
         end
         num = fmul(256'd3, fmul(a.x, a.x));
         den = fadd(a.y, a.y);
      end else begin
         num = fsub(b.y, a.y);
         den = fsub(b.x, a.x);
      end
      l = fmul(num, finv(den));
      r.inf = 1'b0;
      r.x = fsub(fsub(fmul(l, l), a.x), b.x);
      r.y = fsub(fmul(l, fsub(a.x, r.x)), a.y);
      return r;
   endfunction

   // Reference scalar multiply, scanning from the LSB upward.
   function automatic pt_t ref_mul(input logic [255:0] kk, input pt_t p);
      pt_t r, q;
      logic [255:0] rem;
      r = '{inf: 1'b1, x: '0, y: '0};
      q = p;
      rem = kk;
      while (rem != '0) begin
         if (rem[0]) r = ec_add(r, q);
         rem = rem >> 1;
         if (rem != '0) q = ec_add(q, q);
      end
      return r;
   endfunction

   function automatic int exp_pa(input logic [255:0] kk, input logic pi);
      int m;
      m = 0;
      if (kk == '0 || pi) return 0;
      for (int i = 0; i < 256; i++) if (kk[i]) m = i;
      return $countones(kk) + m;
   endfunction

   // ---------------- point_add responder ----------------
   int  cnt = 0;
   pt_t op1, op2, res;

   always @(negedge clk) begin
      if (!rst_n) begin
         cnt = 0;
         pa.pa_done = 1'b0;
         pa.pa_x3 = '0;
         pa.pa_y3 = '0;
         pa.pa_inf3 = 1'b0;
      end else begin
         pa.pa_done = 1'b0;
         if (spur) begin
            pa.pa_done = 1'b1;
            pa.pa_x3 = '1;
            pa.pa_y3 = '1;
            pa.pa_inf3 = 1'b0;
            spur = 1'b0;
         end
         if (cnt > 0) begin
            chk("op_stable", {pa.pa_inf1, pa.pa_x1, pa.pa_y1, pa.pa_inf2, pa.pa_x2, pa.pa_y2} === {op1, op2}, 1'b1);
            cnt--;
            if (cnt == 0) begin
               pa.pa_done = 1'b1;
               pa.pa_x3 = res.x;
               pa.pa_y3 = res.y;
               pa.pa_inf3 = res.inf;
               last_done = cyc;
            end
         end
         if (pa.pa_start === 1'b1) begin
            chk("pa_spacing", 256'((cyc - last_done) >= 2), 256'd1);
            chk("pa_overlap", 256'(cnt), 256'd0);
            op1 = '{inf: pa.pa_inf1, x: pa.pa_x1, y: pa.pa_y1};
            op2 = '{inf: pa.pa_inf2, x: pa.pa_x2, y: pa.pa_y2};
            res = ec_add(op1, op2);
            cnt = lat;
            n_pa++;
         end
      end
   end

   // ---------------- directed run ----------------
   task automatic run(input logic [255:0] kk, input pt_t p, input pt_t e,
                      input bit chk_xy, input bit poke, input int exp_lat);
      int s, base, t;
      @(negedge clk);
      start = 1'b1; k = kk; px = p.x; py = p.y; pinf = p.inf;
      s = cyc; base = n_pa;
      @(negedge clk);
      start = 1'b0; k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      px = '1; py = '0; pinf = 1'b0;
      chk("busy_after_start", 256'(busy), 256'd1);
      if (poke) begin
         start = 1'b1; k = 256'd7; px = G2X; py = G2Y;
         @(negedge clk);
         start = 1'b0;
      end
      t = 0;
      while (done !== 1'b1 && t < LIMIT) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", 256'(done), 256'd1);
      chk("busy_at_done", 256'(busy), 256'd1);
      chk("rinf", 256'(rinf), 256'(e.inf));
      if (chk_xy) begin
         chk("rx", rx, e.x);
         chk("ry", ry, e.y);
      end
      chk("pa_count", 256'(n_pa - base), 256'(exp_pa(kk, p.inf)));
      if (exp_lat >= 0) chk("done_latency", 256'(cyc - s), 256'(exp_lat));
      @(negedge clk);
      chk("done_pulse", 256'(done), 256'd0);
      chk("busy_drop", 256'(busy), 256'd0);
      chk("rinf_hold", 256'(rinf), 256'(e.inf));
      if (chk_xy) chk("rx_hold", rx, e.x);
   endtask

   pt_t g, g2, g3, inf_pt, e5, p;
   logic [255:0] kk;
   int t;
   bit seen;

   initial begin
      g      = '{inf: 1'b0, x: GX,  y: GY};
      g2     = '{inf: 1'b0, x: G2X, y: G2Y};
      g3     = '{inf: 1'b0, x: G3X, y: G3Y};
      inf_pt = '{inf: 1'b1, x: '0,  y: '0};
      start = 1'b0; k = '0; px = '0; py = '0; pinf = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_busy", 256'(busy), 256'd0);
      chk("rst_done", 256'(done), 256'd0);
      chk("rst_rx", rx, '0);
      chk("rst_ry", ry, '0);
      chk("rst_rinf", 256'(rinf), 256'd0);
      chk("rst_pa_start", 256'(pa.pa_start), 256'd0);
      chk("rst_pa_ops", {pa.pa_inf1, pa.pa_x1, pa.pa_y1, pa.pa_inf2, pa.pa_x2, pa.pa_y2} === '0, 1'b1);
      rst_n = 1'b1;

      run(256'd1, g, g,  1'b1, 1'b0, -1);
      run(256'd2, g, g2, 1'b1, 1'b0, -1);
      run(256'd3, g, g3, 1'b1, 1'b0, -1);
      run(256'd0, g, inf_pt, 1'b0, 1'b0, 3);
      run(256'd5, '{inf: 1'b1, x: GX, y: GY}, inf_pt, 1'b0, 1'b0, 3);

      lat = 10;
      e5 = ref_mul(256'd5, g);
      run(256'd5, g, e5, 1'b1, 1'b0, -1);

      // Spurious pa_done in IDLE must not disturb anything.
      @(negedge clk);
      spur = 1'b1;
      repeat (3) @(negedge clk);
      chk("spur_busy", 256'(busy), 256'd0);
      chk("spur_done", 256'(done), 256'd0);
      chk("spur_rx_hold", rx, e5.x);

      // start while busy is ignored.
      run(256'd3, g, g3, 1'b1, 1'b1, -1);

      for (int r = 0; r < 3; r++) begin
         lat = int'($urandom_range(1, 6));
         kk = 256'($urandom_range(1, 65535));
         p = (r == 1) ? g2 : g;
         run(kk, p, ref_mul(kk, p), 1'b1, 1'b0, -1);
      end

      // k equal to the group order: accumulator reaches infinity on the last add.
      lat = 2;
      run(NO, g, inf_pt, 1'b0, 1'b0, -1);

      // Reset while a double is outstanding.
      lat = 10;
      @(negedge clk);
      start = 1'b1; k = 256'd3; px = GX; py = GY; pinf = 1'b0;
      t = n_pa;
      @(negedge clk);
      start = 1'b0;
      while (n_pa - t < 2 && cyc < 100000) begin
         @(negedge clk);
         if (n_pa - t < 2 && done === 1'b1) break;
      end
      chk("midop_reach_dbl", 256'(n_pa - t), 256'd2);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midop_rst_busy", 256'(busy), 256'd0);
      chk("midop_rst_done", 256'(done), 256'd0);
      chk("midop_rst_pa_start", 256'(pa.pa_start), 256'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      chk("midop_no_done", 256'(seen), 256'd0);

      run(256'd1, g, g, 1'b1, 1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
